// File: rtl/regfile_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sequencer_pkg
// Shared widths and enumerations for the register-file sequencer and its ALU.
//   REGFILE_WIDTH      : operand / result / register width
//   REGFILE_ADDR_WIDTH : register address width
//   alu_op_t           : instruction opcode
//   seq_state_t        : sequencer FSM state
// -----------------------------------------------------------------------------
package regfile_sequencer_pkg;

  localparam int REGFILE_WIDTH      = 16;
  localparam int REGFILE_ADDR_WIDTH = 3;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    ADD   = 3'd1,
    SUB   = 3'd2,
    AND   = 3'd3,
    OR    = 3'd4,
    XOR   = 3'd5,
    PASSA = 3'd6,
    LOADI = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/regfile_sequencer_alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU used by the sequencer. Unsigned arithmetic, result
// truncated to DATA_W.
//   i_op     : operation select (alu_op_t)
//   i_a/i_b  : operands A and B
//   i_imm    : immediate, only used by LOADI
//   o_result : operation result
//   o_carry  : ADD carry-out or SUB borrow; 0 for every other operation
// -----------------------------------------------------------------------------
module alu_core
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = REGFILE_WIDTH
) (
  input  alu_op_t           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  // One extra bit so the ADD carry-out falls out of the sum directly.
  logic [DATA_W:0] w_sum;
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      SUB: begin
        o_result = i_a - i_b;
        o_carry  = (i_a < i_b);
      end
      AND:     o_result = i_a & i_b;
      OR:      o_result = i_a | i_b;
      XOR:     o_result = i_a ^ i_b;
      PASSA:   o_result = i_a;
      LOADI:   o_result = i_imm;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
// Initiator-side controller for a dual-read / single-write register file.
// Accepts one instruction per Instr_Valid/Instr_Ready handshake, reads both
// source registers, executes in alu_core and writes the result back.
// One instruction takes four cycles: IDLE -> READ -> EXEC -> WRITE -> IDLE.
//   Clock, Reset_n          : rising-edge clock, async active-low reset
//   Instr_*                 : instruction handshake and fields
//   RF_Read_Addr_1/2        : register file read addresses (hold last value)
//   RF_Data_Out_1/2         : register file combinational read data
//   RF_Write_Addr/Data_In/
//   RF_Write_enable         : register file write port, non-zero only in WRITE
//   Result, Zero, Carry     : last computed result and flags
//   Result_Valid            : one-cycle pulse coincident with the write
//   Busy                    : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = REGFILE_WIDTH,
  parameter int ADDR_W = REGFILE_ADDR_WIDTH
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Instr_Valid,
  output logic              Instr_Ready,
  input  alu_op_t           Instr_Opcode,
  input  logic [ADDR_W-1:0] Instr_Dst,
  input  logic [ADDR_W-1:0] Instr_Src1,
  input  logic [ADDR_W-1:0] Instr_Src2,
  input  logic [DATA_W-1:0] Instr_Imm,
  output logic [ADDR_W-1:0] RF_Read_Addr_1,
  output logic [ADDR_W-1:0] RF_Read_Addr_2,
  input  logic [DATA_W-1:0] RF_Data_Out_1,
  input  logic [DATA_W-1:0] RF_Data_Out_2,
  output logic [ADDR_W-1:0] RF_Write_Addr,
  output logic [DATA_W-1:0] RF_Data_In,
  output logic              RF_Write_enable,
  output logic [DATA_W-1:0] Result,
  output logic              Result_Valid,
  output logic              Zero,
  output logic              Carry,
  output logic              Busy
);

  seq_state_t        r_state;
  logic              r_ready;
  logic              r_busy;
  alu_op_t           r_op;
  logic [ADDR_W-1:0] r_dst;
  logic [DATA_W-1:0] r_imm;
  logic [ADDR_W-1:0] r_raddr1;
  logic [ADDR_W-1:0] r_raddr2;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_carry;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_result_valid;

  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op     (r_op),
    .i_a      (r_opa),
    .i_b      (r_opb),
    .i_imm    (r_imm),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

  // NOTE: all state below is sequential, so it uses non-blocking assignments only.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= IDLE;
      r_ready        <= 1'b1;
      r_busy         <= 1'b0;
      r_op           <= NOP;
      r_dst          <= '0;
      r_imm          <= '0;
      r_raddr1       <= '0;
      r_raddr2       <= '0;
      r_opa          <= '0;
      r_opb          <= '0;
      r_result       <= '0;
      r_zero         <= 1'b0;
      r_carry        <= 1'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Instr_Valid && r_ready) begin
            r_op     <= Instr_Opcode;
            r_dst    <= Instr_Dst;
            r_imm    <= Instr_Imm;
            // The read-address registers double as the latched sources, so
            // the addresses are already stable throughout READ.
            r_raddr1 <= Instr_Src1;
            r_raddr2 <= Instr_Src2;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= READ;
          end
        end
        READ: begin
          r_opa   <= RF_Data_Out_1;
          r_opb   <= RF_Data_Out_2;
          r_state <= EXEC;
        end
        EXEC: begin
          // NOP walks through WRITE without touching the result, the flags
          // or the write port.
          if (r_op != NOP) begin
            r_result       <= w_alu_result;
            r_zero         <= (w_alu_result == '0);
            r_carry        <= w_alu_carry;
            r_rf_we        <= 1'b1;
            r_rf_waddr     <= r_dst;
            r_rf_wdata     <= w_alu_result;
            r_result_valid <= 1'b1;
          end
          r_state <= WRITE;
        end
        WRITE: begin
          r_rf_we        <= 1'b0;
          r_rf_waddr     <= '0;
          r_rf_wdata     <= '0;
          r_result_valid <= 1'b0;
          r_ready        <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Instr_Ready     = r_ready;
  assign Busy            = r_busy;
  assign RF_Read_Addr_1  = r_raddr1;
  assign RF_Read_Addr_2  = r_raddr2;
  assign RF_Write_Addr   = r_rf_waddr;
  assign RF_Data_In      = r_rf_wdata;
  assign RF_Write_enable = r_rf_we;
  assign Result          = r_result;
  assign Result_Valid    = r_result_valid;
  assign Zero            = r_zero;
  assign Carry           = r_carry;

endmodule

// File: tb/tb_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_sequencer
// Directed bench for regfile_sequencer with a behavioural register file
// (combinational reads, write on the rising edge, no reset of contents).
// -----------------------------------------------------------------------------
module tb_regfile_sequencer;
  import regfile_sequencer_pkg::*;

  localparam int DW = REGFILE_WIDTH;
  localparam int AW = REGFILE_ADDR_WIDTH;

  logic          Clock;
  logic          Reset_n;
  logic          Instr_Valid;
  logic          Instr_Ready;
  alu_op_t       Instr_Opcode;
  logic [AW-1:0] Instr_Dst;
  logic [AW-1:0] Instr_Src1;
  logic [AW-1:0] Instr_Src2;
  logic [DW-1:0] Instr_Imm;
  logic [AW-1:0] RF_Read_Addr_1;
  logic [AW-1:0] RF_Read_Addr_2;
  logic [DW-1:0] RF_Data_Out_1;
  logic [DW-1:0] RF_Data_Out_2;
  logic [AW-1:0] RF_Write_Addr;
  logic [DW-1:0] RF_Data_In;
  logic          RF_Write_enable;
  logic [DW-1:0] Result;
  logic          Result_Valid;
  logic          Zero;
  logic          Carry;
  logic          Busy;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;

  regfile_sequencer dut (
    .Clock           (Clock),
    .Reset_n         (Reset_n),
    .Instr_Valid     (Instr_Valid),
    .Instr_Ready     (Instr_Ready),
    .Instr_Opcode    (Instr_Opcode),
    .Instr_Dst       (Instr_Dst),
    .Instr_Src1      (Instr_Src1),
    .Instr_Src2      (Instr_Src2),
    .Instr_Imm       (Instr_Imm),
    .RF_Read_Addr_1  (RF_Read_Addr_1),
    .RF_Read_Addr_2  (RF_Read_Addr_2),
    .RF_Data_Out_1   (RF_Data_Out_1),
    .RF_Data_Out_2   (RF_Data_Out_2),
    .RF_Write_Addr   (RF_Write_Addr),
    .RF_Data_In      (RF_Data_In),
    .RF_Write_enable (RF_Write_enable),
    .Result          (Result),
    .Result_Valid    (Result_Valid),
    .Zero            (Zero),
    .Carry           (Carry),
    .Busy            (Busy)
  );

  // Behavioural register file.
  logic [DW-1:0] rf [1<<AW];
  always @(posedge Clock) begin
    if (RF_Write_enable) rf[RF_Write_Addr] <= RF_Data_In;
  end
  assign RF_Data_Out_1 = rf[RF_Read_Addr_1];
  assign RF_Data_Out_2 = rf[RF_Read_Addr_2];

  // Handshake counter.
  always @(posedge Clock) begin
    if (Reset_n && Instr_Valid && Instr_Ready) hs_count <= hs_count + 1;
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!Instr_Ready && k < 16) begin
      @(negedge Clock);
      k++;
    end
    check({tag, "_ready_seen"}, 32'(Instr_Ready), 32'd1);
  endtask

  // Issues one instruction and checks it phase by phase, ending at the
  // negedge of the IDLE cycle that follows WRITE.
  task automatic run_instr(input string tag, input alu_op_t op, input logic [AW-1:0] dst,
                           input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic [DW-1:0] imm, input logic [DW-1:0] exp_res,
                           input logic exp_c);
    logic exp_we;
    exp_we = (op != NOP);
    @(negedge Clock);
    Instr_Opcode = op;
    Instr_Dst    = dst;
    Instr_Src1   = s1;
    Instr_Src2   = s2;
    Instr_Imm    = imm;
    Instr_Valid  = 1'b1;
    wait_ready(tag);
    @(posedge Clock);                    // handshake edge N
    @(negedge Clock);                    // READ
    Instr_Valid = 1'b0;
    check({tag, "_read_busy"},  32'(Busy), 32'd1);
    check({tag, "_read_ready"}, 32'(Instr_Ready), 32'd0);
    check({tag, "_read_addr1"}, 32'(RF_Read_Addr_1), 32'(s1));
    check({tag, "_read_addr2"}, 32'(RF_Read_Addr_2), 32'(s2));
    check({tag, "_read_we"},    32'(RF_Write_enable), 32'd0);
    @(negedge Clock);                    // EXEC
    check({tag, "_exec_we"},    32'(RF_Write_enable), 32'd0);
    @(negedge Clock);                    // WRITE
    check({tag, "_write_we"},   32'(RF_Write_enable), 32'(exp_we));
    check({tag, "_write_rv"},   32'(Result_Valid), 32'(exp_we));
    if (exp_we) begin
      check({tag, "_write_addr"}, 32'(RF_Write_Addr), 32'(dst));
      check({tag, "_write_data"}, 32'(RF_Data_In), 32'(exp_res));
    end
    check({tag, "_result"},     32'(Result), 32'(exp_res));
    check({tag, "_zero"},       32'(Zero), 32'(exp_res == '0));
    check({tag, "_carry"},      32'(Carry), 32'(exp_c));
    @(negedge Clock);                    // back in IDLE, write landed
    check({tag, "_idle_we"},    32'(RF_Write_enable), 32'd0);
    check({tag, "_idle_rv"},    32'(Result_Valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(Instr_Ready), 32'd1);
    check({tag, "_idle_busy"},  32'(Busy), 32'd0);
    if (exp_we) check({tag, "_rf_dst"}, 32'(rf[dst]), 32'(exp_res));
  endtask

  alu_op_t       bb_op  [3];
  logic [AW-1:0] bb_dst [3];
  logic [AW-1:0] bb_s1  [3];
  logic [AW-1:0] bb_s2  [3];
  logic [DW-1:0] bb_imm [3];
  time           t_hs   [3];
  int            hs_before;

  initial begin
    Reset_n      = 1'b0;
    Instr_Valid  = 1'b0;
    Instr_Opcode = NOP;
    Instr_Dst    = '0;
    Instr_Src1   = '0;
    Instr_Src2   = '0;
    Instr_Imm    = '0;

    // Reset state.
    repeat (2) @(negedge Clock);
    check("rst_ready",  32'(Instr_Ready), 32'd1);
    check("rst_busy",   32'(Busy), 32'd0);
    check("rst_we",     32'(RF_Write_enable), 32'd0);
    check("rst_rv",     32'(Result_Valid), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_zero",   32'(Zero), 32'd0);
    check("rst_carry",  32'(Carry), 32'd0);
    check("rst_raddr1", 32'(RF_Read_Addr_1), 32'd0);
    Reset_n = 1'b1;

    // LOADI, then ADD wrapping to zero with carry.
    run_instr("loadi_r3", LOADI, 3'd3, 3'd0, 3'd0, 16'h00A5, 16'h00A5, 1'b0);
    check("loadi_r3_final", 32'(rf[3]), 32'h00A5);
    run_instr("loadi_r1", LOADI, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    run_instr("loadi_r2", LOADI, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0);
    run_instr("add_r4",   ADD,   3'd4, 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b1);

    // SUB with borrow, Dst == Src1, then PASSA of the freshly written value.
    run_instr("loadi_r1b", LOADI, 3'd1, 3'd0, 3'd0, 16'h0003, 16'h0003, 1'b0);
    run_instr("loadi_r2b", LOADI, 3'd2, 3'd0, 3'd0, 16'h0005, 16'h0005, 1'b0);
    run_instr("sub_r1",    SUB,   3'd1, 3'd1, 3'd2, 16'h0000, 16'hFFFE, 1'b1);
    run_instr("passa_r6",  PASSA, 3'd6, 3'd1, 3'd0, 16'h0000, 16'hFFFE, 1'b0);

    // Three back-to-back instructions with Instr_Valid held high.
    bb_op[0] = LOADI; bb_dst[0] = 3'd7; bb_s1[0] = 3'd0; bb_s2[0] = 3'd0; bb_imm[0] = 16'h0F0F;
    bb_op[1] = LOADI; bb_dst[1] = 3'd0; bb_s1[1] = 3'd0; bb_s2[1] = 3'd0; bb_imm[1] = 16'h00FF;
    bb_op[2] = OR;    bb_dst[2] = 3'd5; bb_s1[2] = 3'd7; bb_s2[2] = 3'd0; bb_imm[2] = 16'h0000;
    @(negedge Clock);
    hs_before   = hs_count;
    Instr_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Instr_Opcode = bb_op[i];
      Instr_Dst    = bb_dst[i];
      Instr_Src1   = bb_s1[i];
      Instr_Src2   = bb_s2[i];
      Instr_Imm    = bb_imm[i];
      wait_ready($sformatf("bb%0d", i));
      @(posedge Clock);
      t_hs[i] = $time;
      @(negedge Clock);
      check($sformatf("bb%0d_ready_low", i), 32'(Instr_Ready), 32'd0);
      check($sformatf("bb%0d_busy", i),      32'(Busy), 32'd1);
    end
    Instr_Valid = 1'b0;
    repeat (3) @(negedge Clock);
    check("bb_handshakes", 32'(hs_count - hs_before), 32'd3);
    check("bb_gap01", 32'(t_hs[1] - t_hs[0]), 32'd40);
    check("bb_gap12", 32'(t_hs[2] - t_hs[1]), 32'd40);
    check("bb_r5",    32'(rf[5]), 32'h0FFF);
    check("bb_r7",    32'(rf[7]), 32'h0F0F);

    // NOP leaves the register file, the result and the flags alone.
    run_instr("loadi_r2c", LOADI, 3'd2, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0);
    run_instr("add_r4b",   ADD,   3'd4, 3'd1, 3'd2, 16'h0000, 16'h1232, 1'b1);
    run_instr("nop_r2",    NOP,   3'd2, 3'd3, 3'd4, 16'h5555, 16'h1232, 1'b1);
    check("nop_r2_kept", 32'(rf[2]), 32'h1234);

    // Reset pulsed mid-EXEC aborts the write.
    run_instr("loadi_r5", LOADI, 3'd5, 3'd0, 3'd0, 16'hABCD, 16'hABCD, 1'b0);
    @(negedge Clock);
    Instr_Opcode = ADD;
    Instr_Dst    = 3'd5;
    Instr_Src1   = 3'd3;
    Instr_Src2   = 3'd3;
    Instr_Imm    = 16'h0000;
    Instr_Valid  = 1'b1;
    wait_ready("rst_add");
    @(posedge Clock);
    @(negedge Clock);                    // READ
    Instr_Valid = 1'b0;
    @(negedge Clock);                    // EXEC
    #1;
    Reset_n      = 1'b0;
    // An instruction offered during reset must be ignored.
    Instr_Opcode = LOADI;
    Instr_Imm    = 16'h0000;
    Instr_Valid  = 1'b1;
    #1;
    check("arst_busy",   32'(Busy), 32'd0);
    check("arst_ready",  32'(Instr_Ready), 32'd1);
    check("arst_we",     32'(RF_Write_enable), 32'd0);
    check("arst_rv",     32'(Result_Valid), 32'd0);
    check("arst_result", 32'(Result), 32'd0);
    check("arst_carry",  32'(Carry), 32'd0);
    check("arst_raddr1", 32'(RF_Read_Addr_1), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    Instr_Valid = 1'b0;
    Reset_n     = 1'b1;
    @(negedge Clock);
    check("post_rst_ready", 32'(Instr_Ready), 32'd1);
    check("post_rst_busy",  32'(Busy), 32'd0);
    check("post_rst_we",    32'(RF_Write_enable), 32'd0);
    check("post_rst_r5",    32'(rf[5]), 32'hABCD);

    // Normal operation resumes after reset.
    run_instr("xor_r6", XOR, 3'd6, 3'd5, 3'd3, 16'h0000, 16'hAB68, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
Initiator-side controller for the dual-read / single-write register file. It accepts one register-to-register instruction per valid/ready handshake and drives the register file read addresses. It captures both operands, executes the operation in an internal ALU, and writes the result back through the single write port. The block sits between the instruction source (testbench or a future fetch stage) and register_file, and owns every register file address, data and write-enable signal.

Parameters:
DATA_W, REGFILE_WIDTH (package), operand / result / register width
ADDR_W, REGFILE_ADDR_WIDTH (package), register address width

Ports:
Clock  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
Instr_Valid  input  1  instruction fields valid
Instr_Ready  output  1  sequencer can accept an instruction
Instr_Opcode  input  3  alu_op_t operation
Instr_Dst  input  ADDR_W  destination register
Instr_Src1  input  ADDR_W  operand A register
Instr_Src2  input  ADDR_W  operand B register
Instr_Imm  input  DATA_W  immediate, used by LOADI only
RF_Read_Addr_1  output  ADDR_W  register file read port 1 address
RF_Read_Addr_2  output  ADDR_W  register file read port 2 address
RF_Data_Out_1  input  DATA_W  register file read data 1 (combinational)
RF_Data_Out_2  input  DATA_W  register file read data 2 (combinational)
RF_Write_Addr  output  ADDR_W  register file write address
RF_Data_In  output  DATA_W  register file write data
RF_Write_enable  output  1  register file write strobe
Result  output  DATA_W  last computed result
Result_Valid  output  1  one-cycle pulse coincident with the write
Zero  output  1  last result == 0
Carry  output  1  ADD carry-out / SUB borrow
Busy  output  1  state != IDLE

Behaviour:
- Reset: asynchronous on Reset_n low, regardless of Clock.
  - State goes to IDLE.
  - All outputs and internal registers go to 0, except Instr_Ready, which is 1.
  - An in-flight write is aborted: RF_Write_enable drops immediately.
  - Register file contents are not touched.
- FSM states: IDLE, READ, EXEC, WRITE. Instr_Ready = 1 only in IDLE.
- IDLE: handshake at edge N when Instr_Valid && Instr_Ready.
  - Latch Opcode, Dst, Src1, Src2, Imm.
  - Go to READ.
  - Instr_Valid without Ready is ignored; the source must hold its fields until it sees Ready.
- READ (cycle N..N+1):
  - RF_Read_Addr_1/2 driven from the latched Src1/Src2.
  - At edge N+1 latch RF_Data_Out_1/2 into operand A/B, then go to EXEC.
- EXEC (N+1..N+2): at edge N+2 the ALU result, Zero and Carry are registered; go to WRITE.
- WRITE (N+2..N+3):
  - RF_Write_enable = 1, RF_Write_Addr = Dst, RF_Data_In = Result, Result_Valid = 1.
  - The register file captures the data at edge N+3; go to IDLE.
- Latency and throughput: next instruction accepted at edge N+4 at the earliest. Maximum throughput is 1 instruction per 4 cycles.
- No read-after-write hazard: the write lands before the next READ.
- Read addresses hold their last value in all other states.
- Write-port outputs are 0 outside WRITE.
- ALU operations (width DATA_W, unsigned, result truncated to DATA_W):
  - ADD: A+B, Carry = bit DATA_W of the sum.
  - SUB: A-B, Carry = borrow (A<B).
  - AND, OR, XOR: bitwise, Carry = 0.
  - PASSA: A, Carry = 0.
  - LOADI: Imm, Carry = 0; operands are still read but ignored.
  - NOP: passes through all states; RF_Write_enable = 0 and Result_Valid = 0 in WRITE; Result, Zero and Carry are unchanged.
- Zero = (Result == 0), updated together with Result.
- Dst may equal Src1 and/or Src2: the operands were captured in READ, so the write uses the old values.
- Reset asserted in any state returns the block to IDLE with no write issued. An instruction presented during reset is not accepted.

Decomposition:
- Add to ALU_REGFILE_defs:
  - typedef enum logic [2:0] alu_op_t {NOP, ADD, SUB, AND, OR, XOR, PASSA, LOADI}
  - typedef enum logic [1:0] seq_state_t {IDLE, READ, EXEC, WRITE}
- Sub-module alu_core: purely combinational. Inputs: op, a, b, imm. Outputs: result and carry.
- The sequencer registers all ALU outputs. Top-level bench instantiates regfile_sequencer plus register_file.

Test Plan:
- Reset then LOADI Dst=3 Imm=16'h00A5 -> RF_Write_enable high only in cycle N+2..N+3, R3 = 00A5, Zero = 0, Result_Valid one cycle.
- R1=FFFF, R2=0001 via LOADI, then ADD Dst=4 Src1=1 Src2=2 -> R4 = 0000, Carry = 1, Zero = 1.
- R1=0003, R2=0005, SUB Dst=1 Src1=1 Src2=2 -> R1 = FFFE, Carry = 1; a following PASSA Dst=6 Src1=1 reads FFFE, confirming no hazard.
- Instr_Valid held high for 3 back-to-back instructions -> exactly 3 handshakes at edges 4 cycles apart; Instr_Ready low while Busy.
- NOP with Dst=2 after R2=1234 -> RF_Write_enable never asserts, R2 stays 1234, Result, Zero and Carry unchanged.
- Reset_n pulsed low mid-EXEC of ADD Dst=5 -> outputs clear asynchronously, no write occurs, R5 unchanged, Instr_Ready = 1 on the next cycle.
